vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_pkg.sv | 20 ++
 rtl/fb_addr_calc.sv | 19 +
 rtl/vga_fb_arbiter.sv | 125 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared framebuffer geometry and VGA timing constants for the display/coprocessor arbiter.
package vga_fb_pkg;

    localparam int unsigned FB_W      = 320;
    localparam int unsigned FB_H      = 240;
    localparam int unsigned FB_AW     = 17;
    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned H_TOTAL   = 800;
    localparam int unsigned V_TOTAL   = 525;

    localparam logic [FB_AW-1:0] FB_SIZE = FB_AW'(FB_W * FB_H);

    typedef enum logic [1:0] {
        GntIdle,
        GntRead,
        GntWrite
    } grant_e;

endpackage

// File: rtl/fb_addr_calc.sv
// Row-major framebuffer address: row*320 + col, built from shifts so no multiplier is needed.
module fb_addr_calc
    import vga_fb_pkg::*;
(
    input  logic [7:0]       row_i,
    input  logic [8:0]       col_i,
    output logic [FB_AW-1:0] addr_o
);

    logic [FB_AW-1:0] row_ext;
    logic [FB_AW-1:0] col_ext;

    always_comb begin
        row_ext = {9'd0, row_i};
        col_ext = {8'd0, col_i};
        addr_o  = (row_ext << 8) + (row_ext << 6) + col_ext;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer between the VGA display fetch (always wins) and a
// coprocessor pixel writer that gets every cycle the display does not need.
module vga_fb_arbiter
    import vga_fb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       vga_x,
    input  logic [9:0]       vga_y,
    input  logic             wr_valid,
    input  logic [FB_AW-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic [FB_AW-1:0] ram_addr,
    output logic             ram_we,
    output logic [7:0]       ram_wdata,
    input  logic [7:0]       ram_rdata,
    output logic [7:0]       pixel_out,
    output logic             underrun
);

    localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
    localparam logic [9:0] XLineEnd = 10'(H_TOTAL - 4);

    logic [9:0]       prev_x_q;
    logic             disp_pending_q;
    logic [FB_AW-1:0] pend_addr_q;
    logic             cap_q;
    logic [7:0]       next_pix_q;
    logic [FB_AW-1:0] addr_q;
    logic [7:0]       wdata_q;

    logic             x_step;
    logic [9:0]       next_y;
    logic             trig_a;
    logic             trig_b;
    logic             trigger;
    logic             pix_upd;
    logic [7:0]       fetch_row;
    logic [8:0]       fetch_col;
    logic [FB_AW-1:0] fetch_addr;
    grant_e           grant;

    always_comb begin
        x_step  = (vga_x != prev_x_q);
        next_y  = (vga_y == VLast) ? 10'd0 : vga_y + 10'd1;
        // Fetch one stored pixel ahead of the one currently being shown.
        trig_a  = x_step && !vga_x[0] && (vga_x < 10'(H_DISPLAY - 2)) &&
                  (vga_y < 10'(V_DISPLAY));
        trig_b  = x_step && (vga_x == XLineEnd) && (next_y < 10'(V_DISPLAY));
        trigger = trig_a || trig_b;
        pix_upd = x_step && !vga_x[0] && (vga_x < 10'(H_DISPLAY)) &&
                  (vga_y < 10'(V_DISPLAY));
        fetch_row = trig_b ? next_y[8:1] : vga_y[8:1];
        fetch_col = trig_b ? 9'd0 : vga_x[9:1] + 9'd1;
    end

    fb_addr_calc u_addr_calc (
        .row_i  (fetch_row),
        .col_i  (fetch_col),
        .addr_o (fetch_addr)
    );

    always_comb begin
        if (reset) begin
            grant = GntIdle;
        end else if (disp_pending_q) begin
            grant = GntRead;
        end else if (wr_valid) begin
            grant = GntWrite;
        end else begin
            grant = GntIdle;
        end
    end

    always_comb begin
        ram_addr  = reset ? '0 : addr_q;
        ram_wdata = reset ? '0 : wdata_q;
        ram_we    = 1'b0;
        wr_ready  = !reset && !disp_pending_q;
        unique case (grant)
            GntRead: ram_addr = pend_addr_q;
            GntWrite: begin
                ram_addr  = wr_addr;
                ram_wdata = wr_data;
                // Out-of-range writes complete the handshake but never reach the RAM.
                ram_we    = (wr_addr < FB_SIZE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_x_q       <= vga_x;
            disp_pending_q <= 1'b0;
            pend_addr_q    <= '0;
            cap_q          <= 1'b0;
            next_pix_q     <= '0;
            pixel_out      <= '0;
            underrun       <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
        end else begin
            prev_x_q <= vga_x;
            addr_q   <= ram_addr;
            wdata_q  <= ram_wdata;
            cap_q    <= (grant == GntRead);
            if (cap_q) begin
                next_pix_q <= ram_rdata;
            end
            if (pix_upd) begin
                pixel_out <= next_pix_q;
            end
            disp_pending_q <= trigger;
            if (trigger) begin
                pend_addr_q <= fetch_addr;
                if (disp_pending_q || cap_q) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed scan/write vectors; expected RAM commands go to a scoreboard checked by a monitor.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  vga_x;
    logic [9:0]  vga_y;
    logic        wr_valid;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  pixel_out;
    logic        underrun;

    vga_fb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .pixel_out (pixel_out),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data is the low byte of the address, one clock later.
    always @(posedge clk) ram_rdata <= ram_addr[7:0];

    typedef struct {
        int          cyc;
        bit          rd;
        bit          we;
        bit          chk_addr;
        logic [16:0] addr;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        bit rst;
        int x;
        int y;
        bit wv;
        int wa;
        int wd;
        bit rd;
        int ra;
        int pix;
        int und;
        bit q;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    bit   mon_en = 1'b0;

    function automatic vec_t v(bit rst, int x, int y, bit wv, int wa, int wd, bit rd, int ra,
                               int pix, int und, bit q);
        vec_t r;
        r.rst = rst; r.x = x; r.y = y; r.wv = wv; r.wa = wa; r.wd = wd;
        r.rd = rd; r.ra = ra; r.pix = pix; r.und = und; r.q = q;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run_row(input vec_t r);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = r.rst;
        vga_x    = r.x[9:0];
        vga_y    = r.y[9:0];
        wr_valid = r.wv;
        wr_addr  = r.wa[16:0];
        wr_data  = r.wd[7:0];
        e.cyc = cyc;
        if (r.rd) begin
            e.rd = 1'b1; e.we = 1'b0; e.chk_addr = 1'b1; e.addr = r.ra[16:0]; e.data = 8'h00;
            sb.push_back(e);
        end else if (r.wv && !r.rst) begin
            e.rd = 1'b0; e.we = (r.wa < 76800); e.chk_addr = e.we;
            e.addr = r.wa[16:0]; e.data = r.wd[7:0];
            sb.push_back(e);
        end
        @(negedge clk);
        if (r.pix >= 0) check("pixel_out", {24'd0, pixel_out}, r.pix);
        if (r.und >= 0) check("underrun", {31'd0, underrun}, r.und);
        if (r.q) begin
            check("wr_ready after reset", {31'd0, wr_ready}, 1);
            check("ram_we after reset", {31'd0, ram_we}, 0);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   rd_obs;
        bit   wr_obs;
        if (mon_en && reset === 1'b0) begin
            rd_obs = (wr_ready === 1'b0);
            wr_obs = (wr_valid === 1'b1) && (wr_ready === 1'b1);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing ram cmd: got none expected rd=%0d addr=%0d at cycle %0d",
                         e.rd, e.addr, e.cyc);
            end
            if (rd_obs || wr_obs) begin
                n_cmp++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    n_bad++;
                    $display("FAIL unexpected ram cmd: got rd=%0d we=%0d addr=%0d expected none (cycle %0d)",
                             rd_obs, ram_we, ram_addr, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.rd != rd_obs || ram_we !== e.we ||
                        (e.chk_addr && ram_addr !== e.addr) ||
                        (e.we && ram_wdata !== e.data)) begin
                        n_bad++;
                        $display("FAIL ram cmd: got rd=%0d we=%0d addr=%0d data=%0d expected rd=%0d we=%0d addr=%0d data=%0d (cycle %0d)",
                                 rd_obs, ram_we, ram_addr, ram_wdata,
                                 e.rd, e.we, e.addr, e.data, cyc);
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        //                 rst x    y    wv wa     wd    rd ra    pix  und  q
        vecs.push_back(v(0, 795, 524, 0, 0,     0,    0, 0,    -1,  -1,  0)); // 0
        vecs.push_back(v(0, 796, 524, 0, 0,     0,    0, 0,    -1,  -1,  0)); // trigger B -> row 0
        vecs.push_back(v(0, 796, 524, 0, 0,     0,    1, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 797, 524, 0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 797, 524, 0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 798, 524, 0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 798, 524, 0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 799, 524, 0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 799, 524, 0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 0,   0,   0, 0,     0,    0, 0,    -1,  -1,  0)); // 9
        vecs.push_back(v(0, 0,   0,   0, 0,     0,    1, 1,    -1,  -1,  0));
        vecs.push_back(v(0, 1,   0,   0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 1,   0,   0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 2,   0,   0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 2,   0,   0, 0,     0,    1, 2,    1,   -1,  0));
        vecs.push_back(v(0, 3,   0,   0, 0,     0,    0, 0,    -1,  -1,  0)); // 15
        vecs.push_back(v(0, 3,   0,   0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 4,   0,   0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 4,   0,   0, 0,     0,    1, 3,    2,   -1,  0));
        vecs.push_back(v(0, 635, 0,   0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 636, 0,   0, 0,     0,    0, 0,    -1,  -1,  0)); // 20: col 319
        vecs.push_back(v(0, 636, 0,   0, 0,     0,    1, 319,  3,   -1,  0));
        vecs.push_back(v(0, 637, 0,   0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 637, 0,   0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 638, 0,   0, 0,     0,    0, 0,    -1,  -1,  0)); // no fetch at 638
        vecs.push_back(v(0, 638, 0,   0, 0,     0,    0, 0,    63,  0,   0)); // 25
        vecs.push_back(v(0, 795, 1,   0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 796, 1,   0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 796, 1,   0, 0,     0,    1, 320,  -1,  -1,  0));
        vecs.push_back(v(0, 795, 479, 0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 796, 479, 0, 0,     0,    0, 0,    -1,  -1,  0)); // 30: next line 480
        vecs.push_back(v(0, 796, 479, 0, 0,     0,    0, 0,    -1,  0,   0));
        vecs.push_back(v(0, 9,   2,   1, 1000,  1,    0, 0,    -1,  -1,  0)); // active-line writes
        vecs.push_back(v(0, 10,  2,   1, 1001,  2,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 10,  2,   1, 1002,  3,    1, 326,  -1,  -1,  0));
        vecs.push_back(v(0, 11,  2,   1, 1002,  3,    0, 0,    -1,  -1,  0)); // 35
        vecs.push_back(v(0, 11,  2,   1, 1003,  4,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 12,  2,   1, 1004,  5,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 12,  2,   1, 1005,  6,    1, 327,  -1,  -1,  0));
        vecs.push_back(v(0, 13,  2,   1, 1005,  6,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 13,  2,   1, 1006,  7,    0, 0,    -1,  -1,  0)); // 40
        vecs.push_back(v(0, 101, 500, 1, 5,     8'h11, 0, 0,   -1,  -1,  0)); // vblank writes
        vecs.push_back(v(0, 102, 500, 1, 6,     8'h22, 0, 0,   -1,  -1,  0));
        vecs.push_back(v(0, 102, 500, 1, 76800, 8'h33, 0, 0,   -1,  -1,  0));
        vecs.push_back(v(0, 103, 500, 1, 76799, 8'h44, 0, 0,   -1,  -1,  0));
        vecs.push_back(v(0, 103, 500, 1, 7,     8'h55, 0, 0,   -1,  -1,  0)); // 45
        vecs.push_back(v(0, 103, 500, 0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 20,  10,  0, 0,     0,    0, 0,    -1,  0,   0)); // double-rate x
        vecs.push_back(v(0, 21,  10,  0, 0,     0,    1, 1611, -1,  0,   0));
        vecs.push_back(v(0, 22,  10,  0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 23,  10,  0, 0,     0,    1, 1612, -1,  1,   0)); // 50
        vecs.push_back(v(0, 24,  10,  0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 25,  10,  0, 0,     0,    1, 1613, -1,  1,   0));
        vecs.push_back(v(0, 25,  10,  0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 27,  600, 0, 0,     0,    0, 0,    -1,  1,   0));
        vecs.push_back(v(0, 27,  600, 0, 0,     0,    0, 0,    -1,  1,   0)); // 55
        vecs.push_back(v(0, 29,  4,   0, 0,     0,    0, 0,    -1,  1,   0));
        vecs.push_back(v(0, 30,  4,   0, 0,     0,    0, 0,    -1,  -1,  0)); // trigger -> 656
        vecs.push_back(v(1, 30,  4,   0, 0,     0,    0, 0,    -1,  -1,  0)); // reset mid-read
        vecs.push_back(v(0, 30,  4,   0, 0,     0,    0, 0,    0,   0,   1));
        vecs.push_back(v(0, 31,  4,   0, 0,     0,    0, 0,    -1,  -1,  0)); // 60
        vecs.push_back(v(0, 31,  4,   0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 32,  4,   0, 0,     0,    0, 0,    0,   -1,  0));
        vecs.push_back(v(0, 32,  4,   0, 0,     0,    1, 657,  -1,  -1,  0));
        vecs.push_back(v(0, 33,  4,   0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 33,  4,   0, 0,     0,    0, 0,    -1,  -1,  0)); // 65
        vecs.push_back(v(0, 34,  4,   0, 0,     0,    0, 0,    -1,  -1,  0));
        vecs.push_back(v(0, 34,  4,   0, 0,     0,    1, 658,  145, 0,   0));

        reset    = 1'b1;
        vga_x    = 10'd795;
        vga_y    = 10'd524;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset wr_ready", {31'd0, wr_ready}, 0);
        check("reset ram_we", {31'd0, ram_we}, 0);
        check("reset ram_addr", {15'd0, ram_addr}, 0);
        check("reset ram_wdata", {24'd0, ram_wdata}, 0);
        check("reset pixel_out", {24'd0, pixel_out}, 0);
        check("reset underrun", {31'd0, underrun}, 0);
        mon_en = 1'b1;

        for (int i = 0; i <= 46; i++) run_row(vecs[i]);
        check("idle ram_we", {31'd0, ram_we}, 0);
        check("idle ram_addr held", {15'd0, ram_addr}, 7);
        check("idle ram_wdata held", {24'd0, ram_wdata}, 8'h55);
        check("idle wr_ready", {31'd0, wr_ready}, 1);
        for (int i = 47; i < vecs.size(); i++) run_row(vecs[i]);

        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL leftover ram cmd: got none expected rd=%0d addr=%0d at cycle %0d",
                     e.rd, e.addr, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
